// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one main-memory port between the L1 icache and L1 dcache, round-robin on ties.
// Latency: grant in the request cycle, mem_req_o the next cycle, rvalid one cycle after mem_ack_i.
// Backpressure: one transaction in flight; caches hold req until gnt and wait in IDLE while busy.
module l1_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // icache side
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_rvalid_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  // dcache side
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_rvalid_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  // memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  // status
  output logic              busy_o,
  output logic [31:0]       ic_cnt_o,
  output logic [31:0]       dc_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Owner encoding shared by owner_q and last_owner_q.
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_t              state_q;
  state_t              state_d;
  logic                owner_q;
  logic                last_owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic [31:0]         ic_cnt_q;
  logic [31:0]         dc_cnt_q;

  logic                grant_ic;
  logic                grant_dc;
  logic                ack_take;

  // Arbitration and next-state: grants only from IDLE, tie goes to whoever did not win last.
  // Grants are masked while reset is asserted so a held request cannot leak a gnt pulse.
  always_comb begin
    state_d  = state_q;
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    ack_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rst_ni) begin
          if (dc_req_i && (!ic_req_i || (last_owner_q == OWN_IC))) begin
            grant_dc = 1'b1;
          end else if (ic_req_i) begin
            grant_ic = 1'b1;
          end
        end
        if (grant_ic || grant_dc) begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        // Ack only counts while the request is actually on the bus.
        if (mem_ack_i) begin
          ack_take = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning request so the memory bus stays stable for the whole transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q      <= OWN_IC;
      last_owner_q <= OWN_IC;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else if (grant_dc) begin
      owner_q      <= OWN_DC;
      last_owner_q <= OWN_DC;
      addr_q       <= dc_addr_i;
      we_q         <= dc_we_i;
      wdata_q      <= dc_wdata_i;
    end else if (grant_ic) begin
      owner_q      <= OWN_IC;
      last_owner_q <= OWN_IC;
      addr_q       <= ic_addr_i;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end
  end

  // Latch read data on ack; write-backs return an all-zero line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (ack_take) begin
      rdata_q <= we_q ? '0 : mem_rdata_i;
    end
  end

  // Per-cache grant counters; natural 32-bit wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ic_cnt_q <= '0;
      dc_cnt_q <= '0;
    end else begin
      if (grant_ic) begin
        ic_cnt_q <= ic_cnt_q + 32'd1;
      end
      if (grant_dc) begin
        dc_cnt_q <= dc_cnt_q + 32'd1;
      end
    end
  end

  assign ic_gnt_o    = grant_ic;
  assign dc_gnt_o    = grant_dc;

  assign ic_rvalid_o = (state_q == ST_RESP) && (owner_q == OWN_IC);
  assign dc_rvalid_o = (state_q == ST_RESP) && (owner_q == OWN_DC);
  assign ic_rdata_o  = rdata_q;
  assign dc_rdata_o  = rdata_q;

  assign mem_req_o   = (state_q == ST_MEM);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign busy_o      = (state_q != ST_IDLE);
  assign ic_cnt_o    = ic_cnt_q;
  assign dc_cnt_o    = dc_cnt_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed stimulus with a scoreboard for l1_mem_arbiter.
// Latency: responder acks after a programmable number of mem_req cycles.
// Backpressure: caches hold req until gnt; every wait is bounded by a cycle budget.
module tb_l1_mem_arbiter;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          ic_req_i, ic_gnt_o, ic_rvalid_o;
  logic [31:0]   ic_addr_i;
  logic [127:0]  ic_rdata_o;
  logic          dc_req_i, dc_we_i, dc_gnt_o, dc_rvalid_o;
  logic [31:0]   dc_addr_i;
  logic [127:0]  dc_wdata_i, dc_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]   mem_addr_o;
  logic [127:0]  mem_wdata_o, mem_rdata_i;
  logic          busy_o;
  logic [31:0]   ic_cnt_o, dc_cnt_o;

  logic          resp_ack;
  logic          stray_ack;
  logic          resp_en;
  int            mem_delay;

  l1_mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_gnt_o(dc_gnt_o), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .ic_cnt_o(ic_cnt_o), .dc_cnt_o(dc_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents are a fixed function of the address.
  function automatic logic [127:0] mem_model(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1111_1111};
  endfunction

  assign mem_ack_i   = resp_ack | stray_ack;
  assign mem_rdata_i = mem_model(mem_addr_o);

  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic         dc;
    logic [127:0] data;
  } rsp_exp_t;

  logic     exp_gnt_q[$];
  mem_exp_t exp_mem_q[$];
  rsp_exp_t exp_rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor-side bookkeeping (written only by the monitor).
  int cyc = 0;
  int t_gnt, t_mem_rise, t_ack, t_rv;
  int busy_total = 0;
  int rvalid_total = 0;
  logic prev_mem_req = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard monitor: pops and compares whenever the DUT presents an event.
  initial begin
    logic     eg;
    mem_exp_t em;
    rsp_exp_t er;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (busy_o) busy_total++;
        if (ic_gnt_o || dc_gnt_o) begin
          t_gnt = cyc;
          if (exp_gnt_q.size() == 0) begin
            chk("gnt_unexpected", 128'({ic_gnt_o, dc_gnt_o}), 128'd0);
          end else begin
            eg = exp_gnt_q.pop_front();
            chk("gnt_who", 128'({ic_gnt_o, dc_gnt_o}), eg ? 128'd1 : 128'd2);
          end
        end
        if (mem_req_o) begin
          if (!prev_mem_req) t_mem_rise = cyc;
          if (exp_mem_q.size() == 0) begin
            chk("mem_unexpected", 128'(mem_req_o), 128'd0);
          end else begin
            em = exp_mem_q[0];
            chk("mem_we", 128'(mem_we_o), 128'(em.we));
            chk("mem_addr", 128'(mem_addr_o), 128'(em.addr));
            chk("mem_wdata", mem_wdata_o, em.wdata);
            if (mem_ack_i) begin
              t_ack = cyc;
              void'(exp_mem_q.pop_front());
            end
          end
        end
        if (ic_rvalid_o || dc_rvalid_o) begin
          t_rv = cyc;
          rvalid_total++;
          if (exp_rsp_q.size() == 0) begin
            chk("rvalid_unexpected", 128'({ic_rvalid_o, dc_rvalid_o}), 128'd0);
          end else begin
            er = exp_rsp_q.pop_front();
            chk("rsp_who", 128'({ic_rvalid_o, dc_rvalid_o}), er.dc ? 128'd1 : 128'd2);
            chk("rsp_data", dc_rvalid_o ? dc_rdata_o : ic_rdata_o, er.data);
          end
        end
        prev_mem_req = mem_req_o;
      end else begin
        prev_mem_req = 1'b0;
      end
    end
  end

  // Memory responder: ack after mem_delay cycles of mem_req_o.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    resp_ack = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      resp_ack = 1'b0;
      if (mem_req_o && resp_en && rst_ni) begin
        if (wait_cnt >= mem_delay) begin
          resp_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic issue_ic(input logic [31:0] a);
    rsp_exp_t r;
    ic_addr_i = a;
    ic_req_i  = 1'b1;
    exp_gnt_q.push_back(1'b0);
    exp_mem_q.push_back('{we: 1'b0, addr: a, wdata: 128'd0});
    r.dc = 1'b0; r.data = mem_model(a);
    exp_rsp_q.push_back(r);
  endtask

  task automatic issue_dc(input logic we, input logic [31:0] a, input logic [127:0] wd);
    rsp_exp_t r;
    dc_we_i    = we;
    dc_addr_i  = a;
    dc_wdata_i = wd;
    dc_req_i   = 1'b1;
    exp_gnt_q.push_back(1'b1);
    exp_mem_q.push_back('{we: we, addr: a, wdata: wd});
    r.dc = 1'b1; r.data = we ? 128'd0 : mem_model(a);
    exp_rsp_q.push_back(r);
  endtask

  // Cache behaviour: drop each request the cycle after its grant.
  task automatic run_until_granted(input int budget);
    int n;
    logic drop_ic, drop_dc;
    n = 0;
    while ((ic_req_i || dc_req_i) && n < budget) begin
      @(negedge clk_i);
      drop_ic = ic_gnt_o;
      drop_dc = dc_gnt_o;
      @(posedge clk_i); #1;
      if (drop_ic) ic_req_i = 1'b0;
      if (drop_dc) dc_req_i = 1'b0;
      n++;
    end
    if (ic_req_i || dc_req_i) chk("gnt_timeout", 128'({ic_req_i, dc_req_i}), 128'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while ((busy_o || exp_rsp_q.size() != 0) && n < budget);
    if (busy_o || exp_rsp_q.size() != 0)
      chk("done_timeout", 128'({busy_o, 31'(exp_rsp_q.size())}), 128'd0);
  endtask

  task automatic do_reset();
    ic_req_i = 1'b0;
    dc_req_i = 1'b0;
    rst_ni   = 1'b0;
    #1;
    chk("rst_ctrl", 128'({ic_gnt_o, ic_rvalid_o, dc_gnt_o, dc_rvalid_o, mem_req_o, mem_we_o, busy_o}), 128'd0);
    chk("rst_rdata", ic_rdata_o | dc_rdata_o, 128'd0);
    chk("rst_mem", 128'(mem_addr_o) | mem_wdata_o, 128'd0);
    chk("rst_cnt", 128'({ic_cnt_o, dc_cnt_o}), 128'd0);
    exp_gnt_q.delete();
    exp_mem_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int bsnap, rsnap;
    ic_req_i = 1'b0; ic_addr_i = '0;
    dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0;
    stray_ack = 1'b0; resp_en = 1'b1; mem_delay = 0;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    do_reset();

    // 1: single icache read, ack three cycles after mem_req.
    mem_delay = 3;
    issue_ic(32'h0000_0100);
    run_until_granted(20);
    wait_idle(40);
    chk("t1_gnt_to_req", 128'(t_mem_rise - t_gnt), 128'd1);
    chk("t1_req_to_ack", 128'(t_ack - t_mem_rise), 128'd3);
    chk("t1_ack_to_rv", 128'(t_rv - t_ack), 128'd1);
    chk("t1_ic_cnt", 128'(ic_cnt_o), 128'd1);
    chk("t1_dc_cnt", 128'(dc_cnt_o), 128'd0);

    // 2: ties after reset -> dcache, icache, then dcache again on the next tie.
    do_reset();
    mem_delay = 1;
    issue_dc(1'b0, 32'h0000_3000, 128'd0);
    issue_ic(32'h0000_0140);
    run_until_granted(40);
    wait_idle(40);
    issue_dc(1'b0, 32'h0000_3040, 128'd0);
    issue_ic(32'h0000_0180);
    run_until_granted(40);
    wait_idle(40);
    chk("t2_ic_cnt", 128'(ic_cnt_o), 128'd2);
    chk("t2_dc_cnt", 128'(dc_cnt_o), 128'd2);

    // 3: dcache write-back; returned line must be zero.
    mem_delay = 2;
    issue_dc(1'b1, 32'h0000_2000, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
    run_until_granted(20);
    dc_we_i = 1'b0;
    wait_idle(40);
    chk("t3_dc_cnt", 128'(dc_cnt_o), 128'd3);

    // 4: ack in the first MEM cycle; busy for exactly two cycles.
    mem_delay = 0;
    bsnap = busy_total;
    issue_ic(32'h0000_4440);
    run_until_granted(20);
    wait_idle(40);
    chk("t4_busy_cycles", 128'(busy_total - bsnap), 128'd2);
    chk("t4_req_to_ack", 128'(t_ack - t_mem_rise), 128'd0);
    chk("t4_ack_to_rv", 128'(t_rv - t_ack), 128'd1);

    // Request withdrawn before grant is ignored.
    mem_delay = 3;
    issue_dc(1'b0, 32'h0000_5000, 128'd0);
    run_until_granted(20);
    ic_addr_i = 32'h0000_6000;
    ic_req_i  = 1'b1;
    @(posedge clk_i); #1;
    ic_req_i  = 1'b0;
    wait_idle(40);
    chk("wd_ic_cnt", 128'(ic_cnt_o), 128'd3);
    chk("wd_dc_cnt", 128'(dc_cnt_o), 128'd4);

    // 6: stray acks in IDLE and RESP change nothing.
    rsnap = rvalid_total;
    stray_ack = 1'b1;
    repeat (2) begin
      @(posedge clk_i); #1;
      chk("t6_idle_busy", 128'({busy_o, mem_req_o}), 128'd0);
    end
    stray_ack = 1'b0;
    chk("t6_idle_rvalid", 128'(rvalid_total - rsnap), 128'd0);
    mem_delay = 1;
    issue_dc(1'b0, 32'h0000_7000, 128'd0);
    run_until_granted(20);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk_i);
        n++;
      end while (!(mem_req_o && mem_ack_i) && n < 20);
      if (!(mem_req_o && mem_ack_i)) chk("t6_ack_timeout", 128'(mem_ack_i), 128'd1);
    end
    @(posedge clk_i); #1;
    stray_ack = 1'b1;
    @(posedge clk_i); #1;
    stray_ack = 1'b0;
    chk("t6_resp_busy", 128'({busy_o, mem_req_o}), 128'd0);
    @(posedge clk_i); #1;
    chk("t6_resp_busy2", 128'(busy_o), 128'd0);
    chk("t6_rvalid_count", 128'(rvalid_total - rsnap), 128'd1);

    // 5: reset while in MEM aborts; re-issued request completes.
    resp_en = 1'b0;
    issue_ic(32'h0000_8000);
    run_until_granted(20);
    @(posedge clk_i); #1;
    chk("t5_in_mem", 128'(mem_req_o), 128'd1);
    rsnap = rvalid_total;
    do_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("t5_no_rvalid", 128'(rvalid_total - rsnap), 128'd0);
    resp_en = 1'b1;
    mem_delay = 2;
    issue_ic(32'h0000_8000);
    run_until_granted(20);
    wait_idle(40);
    chk("t5_ic_cnt", 128'(ic_cnt_o), 128'd1);
    chk("t5_dc_cnt", 128'(dc_cnt_o), 128'd0);

    chk("sb_drain", 128'(exp_gnt_q.size() + exp_mem_q.size() + exp_rsp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
